// File: rtl/pixel_stream_arbiter_if.sv
// Bundle of the per-stream source, shared-block and result-stream signals of the pixel arbiter.
// The master view belongs to the arbiter; the slave view belongs to its surroundings.
interface pixel_stream_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   s_valid;
  logic [NUM_CH-1:0]   s_ready;
  logic [8*NUM_CH-1:0] s_data;
  logic [2*NUM_CH-1:0] s_mode;

  logic                dp_valid_in;
  logic                dp_ready_in;
  logic [7:0]          dp_data_in;
  logic [1:0]          dp_mode;
  logic                dp_valid_out;
  logic                dp_ready_out;
  logic [7:0]          dp_data_out;

  logic                m_valid;
  logic                m_ready;
  logic [7:0]          m_data;
  logic [CW-1:0]       m_ch;

  logic                busy;
  logic                err_orphan;

  modport master (
    input  s_valid, s_data, s_mode, dp_ready_in, dp_valid_out, dp_data_out, m_ready,
    output s_ready, dp_valid_in, dp_data_in, dp_mode, dp_ready_out, m_valid, m_data, m_ch,
           busy, err_orphan
  );

  modport slave (
    output s_valid, s_data, s_mode, dp_ready_in, dp_valid_out, dp_data_out, m_ready,
    input  s_ready, dp_valid_in, dp_data_in, dp_mode, dp_ready_out, m_valid, m_data, m_ch,
           busy, err_orphan
  );
endinterface

// File: rtl/pixel_stream_arbiter.sv
// Round-robin sharing of one pixel processing block among NUM_CH streams, with channel tagging of results.
// Define PIX_ARB_BURST_EN to let a channel keep the grant for up to BURST_LEN consecutive pixels.
module pixel_stream_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int TAG_DEPTH = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_stream_arbiter_if.master bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(TAG_DEPTH);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("pixel_stream_arbiter: NUM_CH must be 2..8");
  end
  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pixel_stream_arbiter: TAG_DEPTH must be a power of two >= 2");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("pixel_stream_arbiter: BURST_LEN must be >= 1");
  end

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] last_q, rr_grant, grant, cand;
  logic          rr_found, any_valid, handshake, capture, push, pop, fifo_empty;
  logic [7:0]    sel_data, data_q;
  logic [1:0]    sel_mode, mode_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] tag_mem [TAG_DEPTH];
  logic          err_q;

  assign any_valid  = |bus.s_valid;
  assign handshake  = (state_q == ISSUE) && bus.dp_ready_in;
  assign fifo_empty = (count_q == '0);
  // The registered tag count gates capture; a pop in the same cycle does not free a slot yet.
  assign capture    = !rst && ((state_q == IDLE) || handshake) && any_valid && (count_q < DEPTH);
  assign push       = capture;
  assign pop        = bus.dp_valid_out && bus.dp_ready_out;

  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CW'((int'(last_q) + k) % NUM_CH);
      if (!rr_found && bus.s_valid[cand]) begin
        rr_found = 1'b1;
        rr_grant = cand;
      end
    end
  end

`ifdef PIX_ARB_BURST_EN
  localparam int RW = $clog2(BURST_LEN + 1);
  logic [RW-1:0] run_q;
  logic          sticky;

  // A zero run length means no burst is open yet, so reset does not lock onto channel NUM_CH-1.
  assign sticky = (run_q != '0) && (run_q < RW'(BURST_LEN)) && bus.s_valid[last_q];
  assign grant  = sticky ? last_q : rr_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          run_q <= '0;
    else if (capture) run_q <= sticky ? run_q + 1'b1 : RW'(1);
  end
`else
  assign grant = rr_grant;
`endif

  always_comb begin
    sel_data = '0;
    sel_mode = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CW'(i)) begin
        sel_data = bus.s_data[8*i +: 8];
        sel_mode = bus.s_mode[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (capture)                                    state_d = ISSUE;
    else if (state_q == ISSUE && !bus.dp_ready_in)  state_d = ISSUE;
  end

  always_comb begin
    bus.dp_valid_in = (state_q == ISSUE);
    bus.s_ready     = '0;
    if (capture) bus.s_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= '0;
      last_q <= CW'(NUM_CH - 1);
    end else if (capture) begin
      data_q <= sel_data;
      mode_q <= sel_mode;
      last_q <= grant;
    end
  end

  assign bus.dp_data_in = data_q;
  assign bus.dp_mode    = mode_q;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A result with no outstanding tag cannot be labelled, so it is left unaccepted and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_q <= 1'b0;
    else if (bus.dp_valid_out && fifo_empty)  err_q <= 1'b1;
  end

  assign bus.dp_ready_out = bus.m_ready && !fifo_empty;
  assign bus.m_valid      = bus.dp_valid_out && !fifo_empty;
  assign bus.m_data       = bus.dp_data_out;
  assign bus.m_ch         = fifo_empty ? '0 : tag_mem[rd_ptr_q];
  assign bus.busy         = (state_q == ISSUE) || !fifo_empty;
  assign bus.err_orphan   = err_q;
endmodule

// File: doc/pixel_stream_arbiter.md
# pixel_stream_arbiter

Round-robin scheduler that shares one `data_processing_block` between `NUM_CH` independent pixel streams. Each requester supplies an 8-bit pixel and its own 2-bit mode. The arbiter drives the block's input handshake and tags every issued pixel with its source channel. It then returns each processed result on a single output stream, labelled with that channel. It sits between the per-stream sources and the shared processing block.

## Interface
- `NUM_CH`, 4: number of requesters; legal range 2–8.
- `TAG_DEPTH`, 4: tag FIFO depth, a power of two ≥ 2. Bounds the number of pixels in flight inside the block.
- `BURST_LEN`, 4: maximum consecutive grants to one channel. Used only with `PIX_ARB_BURST_EN`.

Ports, listed as name, direction, width, meaning. `CW = $clog2(NUM_CH)`.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `s_valid` in NUM_CH: per-channel pixel valid.
- `s_ready` out NUM_CH: per-channel accept. At most one bit is set per cycle.
- `s_data` in 8*NUM_CH: pixels; channel i occupies `[8i+7:8i]`.
- `s_mode` in 2*NUM_CH: modes; channel i occupies `[2i+1:2i]`.
- `dp_valid_in` out 1: to the block's `valid_in`.
- `dp_ready_in` in 1: from the block's `ready_in`.
- `dp_data_in` out 8: to the block's `data_in`.
- `dp_mode` out 2: to the block's `mode`.
- `dp_valid_out` in 1: from the block's `valid_out`.
- `dp_ready_out` out 1: to the block's `ready_out`.
- `dp_data_out` in 8: from the block's `data_out`.
- `m_valid` out 1: result valid.
- `m_ready` in 1: downstream accept.
- `m_data` out 8: result pixel.
- `m_ch` out CW: source channel of `m_data`.
- `busy` out 1: high when the issue register or the tag FIFO is non-empty.
- `err_orphan` out 1: sticky error. Set when `dp_valid_out` is high while the tag FIFO is empty.

## Operation
- **Issue FSM** has two states.
  - IDLE: `dp_valid_in`=0.
  - ISSUE: `dp_valid_in`=1, and `dp_data_in`/`dp_mode` are held stable.
- **Capture condition:** (state==IDLE, or a dp handshake this cycle) AND at least one `s_valid` AND tag count < `TAG_DEPTH`.
  - The tag count is the registered value; a simultaneous pop does not free a slot this cycle.
- **On capture:**
  - Assert `s_ready[g]` combinationally for the winner `g`.
  - Register `s_data`/`s_mode` of channel `g` into `dp_data_in`/`dp_mode`.
  - Push `g` into the tag FIFO.
  - Next state is ISSUE.
- **In ISSUE:**
  - With `dp_ready_in`=0: hold state and all outputs.
  - On handshake with no new capture: go to IDLE.
  - On handshake with a new capture: stay in ISSUE with the new pixel. This gives back-to-back throughput of 1 pixel/cycle.
- **Round-robin arbitration:**
  - The pointer `last` holds the most recently granted channel.
  - Search order is `last+1, last+2, …` with wrap-around modulo `NUM_CH`.
  - `last` updates on every capture.
- **Return path:**
  - `m_valid` = `dp_valid_out` & tag FIFO non-empty.
  - `dp_ready_out` = `m_ready` & tag FIFO non-empty.
  - `m_data` = `dp_data_out`, passed combinationally.
  - `m_ch` = tag FIFO head.
  - Pop on `dp_valid_out & dp_ready_out`.
  - A push and a pop in the same cycle are legal and leave the count unchanged.
- **Orphan result:** when `dp_valid_out`=1 with the FIFO empty, `dp_ready_out` stays 0 and `err_orphan` sets. It clears only on `rst`.
- **Ordering:** results are assumed to return in issue order; the block does not reorder them.

## Timing
- **Reset values:** `s_ready`=0, `dp_valid_in`=0, `dp_data_in`=0, `dp_mode`=0, `dp_ready_out`=0, `m_valid`=0, `m_ch`=0, `busy`=0, `err_orphan`=0. State is IDLE, `last`=NUM_CH-1 (so channel 0 wins first), and the tag FIFO is empty.
- **Latency:** capture in cycle N gives `dp_valid_in`=1 in cycle N+1.
- **Downstream stall:** `m_ready`=0 back-pressures the block through `dp_ready_out`. Issue continues until the tag FIFO is full, then all `s_ready` bits stay 0.
- **Reset mid-operation:** an in-flight issue is dropped and tags are discarded. Results the block emits afterwards then count as orphans, so the block and the arbiter must be reset together.
- **Source handshake:** `s_valid` may deassert without a handshake. Arbitration is re-evaluated every cycle.

## Configuration
- `PIX_ARB_BURST_EN` defined:
  - After granting channel g, the arbiter keeps granting g while `s_valid[g]`=1 and the run length is < `BURST_LEN`.
  - When the run reaches `BURST_LEN`, or `s_valid[g]` drops, the normal round-robin search resumes from g+1.
  - The run counter resets to 0 on `rst`.
- `PIX_ARB_BURST_EN` undefined: strict per-beat round robin; `BURST_LEN` is ignored.

## Test plan
- **Reset and single channel.** Reset, then send ch2 `s_valid`, `A5`, mode 00. Expect `s_ready[2]` pulse, `dp_valid_in` next cycle with `A5`/00, and a return with `m_data`=`A5`, `m_ch`=2.
- **Round robin.** All 4 channels valid continuously, with pixels 10/20/30/40 and `dp_ready_in`=1. Expect grant order 0,1,2,3,0…, one pixel per cycle, and `m_ch` sequence matching the grant order.
- **Back-pressure.** Set `m_ready`=0 while 6 pixels are offered. Expect exactly `TAG_DEPTH`=4 pixels issued, then `s_ready`=0. Raising `m_ready` drains the FIFO in order and issue resumes.
- **Mode routing.** ch1 mode 01 with `C2`, ch3 mode 11 with `09`. Expect `dp_mode` 01 then 11, and outputs `C3`/ch1 and `12`/ch3.
- **Orphan error and mid-operation reset.** Pulse `dp_valid_out` with no outstanding tags: `err_orphan`=1 and stays set. Assert `rst` while in ISSUE: all outputs return to reset values within the same cycle.
- **Burst (build with `PIX_ARB_BURST_EN`, `BURST_LEN`=2).** All channels valid. Expect grant order 0,0,1,1,2,2,3,3.
